// File: rtl/oled_spi_pkg.sv
// Shared SSD1351 opcodes, receive-decoder states and coordinate width helper.
package oled_spi_pkg;

  localparam logic [7:0] c_opc_col  = 8'h15;
  localparam logic [7:0] c_opc_row  = 8'h75;
  localparam logic [7:0] c_opc_wram = 8'h5C;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COL_A,
    ST_COL_B,
    ST_ROW_A,
    ST_ROW_B,
    ST_WRAM
  } dec_state_e;

  // Bits needed to address 'size' positions; never less than one.
  function automatic int unsigned coord_bits(input int unsigned size);
    return (size > 1) ? $clog2(size) : 1;
  endfunction

endpackage

// File: rtl/oled_spi_rx_byte_rx.sv
// SPI byte deserializer: pin synchronizers, sample-edge detect, bit counter
// and a one-cycle strobe carrying each completed byte with its dc flag.
module spi_byte_rx #(
  parameter logic c_clk_polarity = 1'b1
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       spi_csn,
  input  logic       spi_clk,
  input  logic       spi_mosi,
  input  logic       spi_dc,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_dc,
  output logic       cs_idle
);

  logic [1:0] csn_q;
  logic [2:0] sclk_q;
  logic [1:0] mosi_q;
  logic [1:0] dc_q;
  logic       armed;
  logic [2:0] bit_cnt;
  logic [6:0] shreg;
  logic       sample_c;

  // Nothing is accepted until csn has been seen high once after reset.
  assign sample_c = armed && !csn_q[1] &&
                    (sclk_q[2] == c_clk_polarity) && (sclk_q[1] != c_clk_polarity);
  assign cs_idle  = csn_q[1];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      csn_q  <= 2'b00;
      sclk_q <= {3{c_clk_polarity}};
      mosi_q <= 2'b00;
      dc_q   <= 2'b00;
    end else begin
      csn_q  <= {csn_q[0], spi_csn};
      sclk_q <= {sclk_q[1:0], spi_clk};
      mosi_q <= {mosi_q[0], spi_mosi};
      dc_q   <= {dc_q[0], spi_dc};
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      armed      <= 1'b0;
      bit_cnt    <= 3'd0;
      shreg      <= 7'd0;
      byte_valid <= 1'b0;
      byte_data  <= 8'd0;
      byte_dc    <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      if (csn_q[1]) begin
        armed   <= 1'b1;
        bit_cnt <= 3'd0;
        shreg   <= 7'd0;
      end else if (sample_c) begin
        shreg   <= {shreg[5:0], mosi_q[1]};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          byte_valid <= 1'b1;
          byte_data  <= {shreg, mosi_q[1]};
          byte_dc    <= dc_q[1];
        end
      end
    end
  end

endmodule

// File: rtl/oled_spi_rx.sv
// Passive SSD1351 SPI decoder: reports commands, arguments and addressed
// pixel writes following the column/row window programmed on the bus.
module oled_spi_rx
  import oled_spi_pkg::*;
#(
  parameter int unsigned c_x_size       = 128,
  parameter int unsigned c_y_size       = 128,
  parameter int unsigned c_color_bits   = 16,
  parameter logic        c_clk_polarity = 1'b1,
  parameter logic [7:0]  c_cmd_col      = c_opc_col,
  parameter logic [7:0]  c_cmd_row      = c_opc_row,
  parameter logic [7:0]  c_cmd_wram     = c_opc_wram
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic                            spi_csn,
  input  logic                            spi_clk,
  input  logic                            spi_mosi,
  input  logic                            spi_dc,
  output logic                            cmd_valid,
  output logic [7:0]                      cmd_byte,
  output logic                            arg_valid,
  output logic [7:0]                      arg_byte,
  output logic                            pixel_valid,
  output logic [coord_bits(c_x_size)-1:0] pixel_x,
  output logic [coord_bits(c_y_size)-1:0] pixel_y,
  output logic [c_color_bits-1:0]         pixel_color,
  output logic                            frame_end
);

  localparam int unsigned xw = coord_bits(c_x_size);
  localparam int unsigned yw = coord_bits(c_y_size);
  localparam int unsigned cw = c_color_bits;

  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_dc;
  logic       cs_idle;

  spi_byte_rx #(
    .c_clk_polarity(c_clk_polarity)
  ) u_byte_rx (
    .clk       (clk),
    .resetn    (resetn),
    .spi_csn   (spi_csn),
    .spi_clk   (spi_clk),
    .spi_mosi  (spi_mosi),
    .spi_dc    (spi_dc),
    .byte_valid(rx_valid),
    .byte_data (rx_data),
    .byte_dc   (rx_dc),
    .cs_idle   (cs_idle)
  );

  dec_state_e    state, state_d;
  logic [xw-1:0] col_start, col_start_d, col_end, col_end_d, x_cnt, x_cnt_d;
  logic [yw-1:0] row_start, row_start_d, row_end, row_end_d, y_cnt, y_cnt_d;
  logic          half, half_d;
  logic [7:0]    hi_byte, hi_byte_d;
  logic          cmd_valid_d, arg_valid_d, pixel_valid_d, frame_end_d;
  logic [7:0]    cmd_byte_d, arg_byte_d;
  logic [xw-1:0] pixel_x_d;
  logic [yw-1:0] pixel_y_d;
  logic [cw-1:0] pixel_color_d;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_d;
  end

  always_comb begin
    state_d       = state;
    col_start_d   = col_start;
    col_end_d     = col_end;
    row_start_d   = row_start;
    row_end_d     = row_end;
    x_cnt_d       = x_cnt;
    y_cnt_d       = y_cnt;
    half_d        = half;
    hi_byte_d     = hi_byte;
    cmd_valid_d   = 1'b0;
    cmd_byte_d    = cmd_byte;
    arg_valid_d   = 1'b0;
    arg_byte_d    = arg_byte;
    pixel_valid_d = 1'b0;
    pixel_x_d     = pixel_x;
    pixel_y_d     = pixel_y;
    pixel_color_d = pixel_color;
    frame_end_d   = 1'b0;

    // Deselect drops any half-assembled pixel.
    if (cs_idle) half_d = 1'b0;

    if (rx_valid) begin
      if (!rx_dc) begin
        cmd_valid_d = 1'b1;
        cmd_byte_d  = rx_data;
        half_d      = 1'b0;
        if (rx_data == c_cmd_col)       state_d = ST_COL_A;
        else if (rx_data == c_cmd_row)  state_d = ST_ROW_A;
        else if (rx_data == c_cmd_wram) state_d = ST_WRAM;
        else                            state_d = ST_IDLE;
      end else begin
        unique case (state)
          ST_COL_A: begin
            arg_valid_d = 1'b1;
            arg_byte_d  = rx_data;
            col_start_d = xw'(rx_data);
            state_d     = ST_COL_B;
          end
          ST_COL_B: begin
            arg_valid_d = 1'b1;
            arg_byte_d  = rx_data;
            col_end_d   = xw'(rx_data);
            x_cnt_d     = col_start;
            state_d     = ST_IDLE;
          end
          ST_ROW_A: begin
            arg_valid_d = 1'b1;
            arg_byte_d  = rx_data;
            row_start_d = yw'(rx_data);
            state_d     = ST_ROW_B;
          end
          ST_ROW_B: begin
            arg_valid_d = 1'b1;
            arg_byte_d  = rx_data;
            row_end_d   = yw'(rx_data);
            y_cnt_d     = row_start;
            state_d     = ST_IDLE;
          end
          ST_WRAM: begin
            if (cw == 16 && !half) begin
              half_d    = 1'b1;
              hi_byte_d = rx_data;
            end else begin
              half_d        = 1'b0;
              pixel_valid_d = 1'b1;
              pixel_x_d     = x_cnt;
              pixel_y_d     = y_cnt;
              pixel_color_d = cw'({hi_byte, rx_data});
              frame_end_d   = (x_cnt == col_end) && (y_cnt == row_end);
              // Raster advance inside the programmed window.
              if (x_cnt == col_end) begin
                x_cnt_d = col_start;
                y_cnt_d = (y_cnt == row_end) ? row_start : y_cnt + yw'(1);
              end else begin
                x_cnt_d = x_cnt + xw'(1);
              end
            end
          end
          default: begin
            arg_valid_d = 1'b1;
            arg_byte_d  = rx_data;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      col_start   <= '0;
      col_end     <= xw'(c_x_size - 1);
      row_start   <= '0;
      row_end     <= yw'(c_y_size - 1);
      x_cnt       <= '0;
      y_cnt       <= '0;
      half        <= 1'b0;
      hi_byte     <= 8'd0;
      cmd_valid   <= 1'b0;
      cmd_byte    <= 8'd0;
      arg_valid   <= 1'b0;
      arg_byte    <= 8'd0;
      pixel_valid <= 1'b0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      pixel_color <= '0;
      frame_end   <= 1'b0;
    end else begin
      col_start   <= col_start_d;
      col_end     <= col_end_d;
      row_start   <= row_start_d;
      row_end     <= row_end_d;
      x_cnt       <= x_cnt_d;
      y_cnt       <= y_cnt_d;
      half        <= half_d;
      hi_byte     <= hi_byte_d;
      cmd_valid   <= cmd_valid_d;
      cmd_byte    <= cmd_byte_d;
      arg_valid   <= arg_valid_d;
      arg_byte    <= arg_byte_d;
      pixel_valid <= pixel_valid_d;
      pixel_x     <= pixel_x_d;
      pixel_y     <= pixel_y_d;
      pixel_color <= pixel_color_d;
      frame_end   <= frame_end_d;
    end
  end

endmodule
